// File: rtl/des_key_sched.sv
// des_key_sched -- sequential DES key-schedule engine.
//
// Registers a 64-bit key, applies PC-1 to form the 28-bit C and D halves, then
// walks the 16-round rotate schedule and presents one PC-2 subkey per
// valid/ready handshake. The engine can sustain one subkey per cycle.
//
// Optional build macro: DES_KEYSCHED_DECRYPT_EN adds the decrypt input. When
// it is set at load, subkeys are produced in reverse order (K16 .. K1).
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   key_load      start strobe; restarts the engine from any state
//   key_in[63:0]  DES key, FIPS bit 1 = key_in[63]; parity bits are ignored
//   decrypt       (macro only) reverse subkey order, latched at load
//   subkey[47:0]  current round subkey, FIPS bit 1 = subkey[47]
//   subkey_valid  subkey holds a valid round key
//   subkey_ready  consumer accepts subkey this cycle
//   round_idx     emission index of subkey, 0..15
//   busy          high from load until the last handshake
//   done          one-cycle pulse after the 16th handshake
//
// state | meaning
// IDLE  | waiting for key_load
// EMIT  | subkey valid, advancing one round per handshake
// FIN   | done pulse, returns to IDLE
module des_key_sched #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_load,
  input  logic [63:0] key_in,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  if (NUM_ROUNDS != 16) begin : gRoundsCheck
    $error("des_key_sched: NUM_ROUNDS must be 16");
  end

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } stateT;

  // FIPS tables are 1-based MSB-first; bit n of a W-bit vector sits at [W-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  // Schedule entry s[idx]: single-bit shift at indices 0, 1, 8 and 15.
  function automatic logic shiftTwo(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  function automatic logic [27:0] rotL(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotR(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  stateT       state, stateNext;
  logic [27:0] cReg, dReg, cNext, dNext;
  logic [47:0] subkeyNext;
  logic [3:0]  rndNext;
  logic        validNext, busyNext, doneNext;

  logic [55:0] keyPc1;
  logic [27:0] loadC, loadD, stepC, stepD;
  logic        loadRev, stepRev;
  logic        unusedParity;

  // Parity bits never reach PC-1.
  assign unusedParity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                          key_in[24], key_in[16], key_in[8], key_in[0]};

`ifdef DES_KEYSCHED_DECRYPT_EN
  logic decryptRun, decryptNext;
  assign loadRev = decrypt;
  assign stepRev = decryptRun;
`else
  assign loadRev = 1'b0;
  assign stepRev = 1'b0;
`endif

  assign keyPc1 = pc1(key_in);

  // Encrypt starts at C1/D1 (rotate by s[0]); decrypt starts at C16/D16,
  // which equals the unrotated PC-1 value since the shifts total 28.
  assign loadC = loadRev ? keyPc1[55:28] : rotL(keyPc1[55:28], 1'b0);
  assign loadD = loadRev ? keyPc1[27:0]  : rotL(keyPc1[27:0],  1'b0);

  // Step into emission rnd+1: forward uses s[rnd+1], reverse undoes s[15-rnd].
  assign stepC = stepRev ? rotR(cReg, shiftTwo(4'd15 - round_idx))
                         : rotL(cReg, shiftTwo(round_idx + 4'd1));
  assign stepD = stepRev ? rotR(dReg, shiftTwo(4'd15 - round_idx))
                         : rotL(dReg, shiftTwo(round_idx + 4'd1));

  always_comb begin
    stateNext  = state;
    cNext      = cReg;
    dNext      = dReg;
    subkeyNext = subkey;
    rndNext    = round_idx;
    validNext  = subkey_valid;
    busyNext   = busy;
    doneNext   = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
    decryptNext = decryptRun;
`endif

    // A load restarts the run from any state and drops any pending subkey.
    if (key_load) begin
      stateNext  = EMIT;
      cNext      = loadC;
      dNext      = loadD;
      subkeyNext = pc2({loadC, loadD});
      rndNext    = 4'd0;
      validNext  = 1'b1;
      busyNext   = 1'b1;
`ifdef DES_KEYSCHED_DECRYPT_EN
      decryptNext = decrypt;
`endif
    end else begin
      case (state)
        IDLE: ;
        EMIT: begin
          if (subkey_valid && subkey_ready) begin
            if (round_idx == 4'd15) begin
              stateNext = FIN;
              validNext = 1'b0;
              busyNext  = 1'b0;
              doneNext  = 1'b1;
            end else begin
              cNext      = stepC;
              dNext      = stepD;
              subkeyNext = pc2({stepC, stepD});
              rndNext    = round_idx + 4'd1;
            end
          end
        end
        FIN:     stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cReg         <= '0;
      dReg         <= '0;
      subkey       <= '0;
      round_idx    <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
      decryptRun   <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      cReg         <= cNext;
      dReg         <= dNext;
      subkey       <= subkeyNext;
      round_idx    <= rndNext;
      subkey_valid <= validNext;
      busy         <= busyNext;
      done         <= doneNext;
`ifdef DES_KEYSCHED_DECRYPT_EN
      decryptRun   <= decryptNext;
`endif
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched -- directed self-checking bench for des_key_sched.
// Table-driven key runs plus hand-written abort, reset and decrypt sequences.
`timescale 1ns/1ps
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_load;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        decrypt;
`endif

  des_key_sched dut (
    .clk          (clk),
    .reset        (reset),
    .key_load     (key_load),
    .key_in       (key_in),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;

  always @(negedge clk) if (done === 1'b1) doneCount++;

  localparam logic [63:0] MAIN_KEY = 64'h133457799BBCDFF1;
  localparam logic [55:0] MAIN_CD0 = 56'hF0CCAAF556678F;

  // Published subkeys K1..K16 for the main key.
  logic [47:0] kEnc [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic [47:0] expSeq [16];

  typedef struct {
    logic [63:0] key;
    bit          stall;
    logic [55:0] cd0;
    int          kind;   // 0: kEnc sequence, 1: all zero, 2: all ones
  } vecT;

  vecT vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fillExp(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       expSeq[i] = kEnc[i];
        1:       expSeq[i] = 48'h0;
        default: expSeq[i] = 48'hFFFFFFFFFFFF;
      endcase
    end
  endtask

  task automatic loadKey(input logic [63:0] k);
    key_in   = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  // Drains a run started by loadKey, comparing against expSeq.
  task automatic collect(input bit stall, input bit checkCd, input logic [55:0] cd0);
    int got;
    int budget;
    int d0;
    bit rdy;
    logic [47:0] holdKey;
    logic [3:0]  holdIdx;
    got = 0;
    budget = 400;
    d0 = doneCount;
    holdKey = '0;
    holdIdx = '0;
    while (got < 16 && budget > 0) begin
      budget--;
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check("valid_in_run", {63'd0, subkey_valid}, 64'd1);
      check("busy_in_run", {63'd0, busy}, 64'd1);
      check("no_early_done", {63'd0, done}, 64'd0);
      if (rdy) begin
        check("subkey", {16'd0, subkey}, {16'd0, expSeq[got]});
        check("round_idx", {60'd0, round_idx}, 64'(got));
        got++;
      end else begin
        holdKey = subkey;
        holdIdx = round_idx;
      end
      subkey_ready = rdy;
      step();
      if (!rdy) begin
        check("stall_subkey", {16'd0, subkey}, {16'd0, holdKey});
        check("stall_idx", {60'd0, round_idx}, {60'd0, holdIdx});
      end
    end
    check("handshakes", 64'(got), 64'd16);
    subkey_ready = 1'b0;
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("valid_at_done", {63'd0, subkey_valid}, 64'd0);
    if (checkCd) check("cd_invariant", {8'd0, dut.cReg, dut.dReg}, {8'd0, cd0});
    step();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_after", {63'd0, busy}, 64'd0);
    check("done_count", 64'(doneCount), 64'(d0 + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset        = 1'b1;
    key_load     = 1'b0;
    key_in       = '0;
    subkey_ready = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
    decrypt      = 1'b0;
`endif
    repeat (3) step();
    check("rst_subkey", {16'd0, subkey}, 64'd0);
    check("rst_valid", {63'd0, subkey_valid}, 64'd0);
    check("rst_round", {60'd0, round_idx}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_cd", {8'd0, dut.cReg, dut.dReg}, 64'd0);

    // Ready in IDLE has no effect.
    reset = 1'b0;
    subkey_ready = 1'b1;
    repeat (3) step();
    check("idle_valid", {63'd0, subkey_valid}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_round", {60'd0, round_idx}, 64'd0);
    subkey_ready = 1'b0;

    vecs[0] = '{MAIN_KEY,              1'b0, MAIN_CD0,              0};
    vecs[1] = '{64'h0000000000000000, 1'b0, 56'h0,                 1};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 56'hFFFFFFFFFFFFFF,    2};
    vecs[3] = '{64'h0101010101010101, 1'b0, 56'h0,                 1};
    vecs[4] = '{MAIN_KEY,              1'b1, MAIN_CD0,              0};

    for (int v = 0; v < 5; v++) begin
      fillExp(vecs[v].kind);
      loadKey(vecs[v].key);
      collect(vecs[v].stall, 1'b1, vecs[v].cd0);
    end

    // New key during round 7 replaces the run; no done for the aborted run.
    fillExp(0);
    loadKey(MAIN_KEY);
    subkey_ready = 1'b1;
    repeat (6) step();
    check("abort_round7_idx", {60'd0, round_idx}, 64'd6);
    check("abort_round7_key", {16'd0, subkey}, {16'd0, kEnc[6]});
    d0 = doneCount;
    key_in   = 64'h0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    subkey_ready = 1'b0;
    check("abort_new_key", {16'd0, subkey}, 64'd0);
    check("abort_new_idx", {60'd0, round_idx}, 64'd0);
    fillExp(1);
    collect(1'b0, 1'b1, 56'h0);
    check("abort_done_count", 64'(doneCount), 64'(d0 + 1));

    // Reset at round 4 with ready high.
    loadKey(MAIN_KEY);
    subkey_ready = 1'b1;
    repeat (3) step();
    check("rstmid_round4", {60'd0, round_idx}, 64'd3);
    d0 = doneCount;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_valid", {63'd0, subkey_valid}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_subkey", {16'd0, subkey}, 64'd0);
    check("rstmid_round", {60'd0, round_idx}, 64'd0);
    repeat (4) step();
    check("rstmid_no_done", 64'(doneCount), 64'(d0));
    check("rstmid_stays_idle", {63'd0, subkey_valid}, 64'd0);
    subkey_ready = 1'b0;

`ifdef DES_KEYSCHED_DECRYPT_EN
    // Reverse order; decrypt is dropped right after load to show it is latched.
    for (int i = 0; i < 16; i++) expSeq[i] = kEnc[15 - i];
    decrypt = 1'b1;
    loadKey(MAIN_KEY);
    decrypt = 1'b0;
    collect(1'b1, 1'b0, 56'h0);
    fillExp(0);
    loadKey(MAIN_KEY);
    collect(1'b0, 1'b1, MAIN_CD0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
